// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serialiser: FSM encodings, counter sizing
// and the default word width.
package piso_pkg;

  localparam int PISO_DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } piso_state_e;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int piso_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a terminal-count flag. It stops at zero and only
// leaves zero through an explicit load.
module piso_bit_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: a load wins over a decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == '0);

endmodule

// File: rtl/parallel_in_serial_out_piso_tx.sv
// Parallel-in serial-out transmitter. Takes words on a valid/ready handshake
// and streams them one bit per clock with a qualifying strobe, a last-bit pulse
// and a busy flag. Outputs are registered; ready is combinational.
module parallel_in_serial_out_piso_tx
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = PISO_DATA_WIDTH_DEFAULT,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Shift_Data_Signal_Out,
  output logic                  Word_Done_Out,
  output logic                  Busy_Out
);

  // One counter serves both the bit count and the gap count, so it is sized
  // for whichever of the two needs more bits.
  localparam int BIT_W = piso_cnt_width(DATA_WIDTH);
  localparam int GAP_W = piso_cnt_width(GAP_CYCLES);
  localparam int CNT_W = (BIT_W > GAP_W) ? BIT_W : GAP_W;
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  piso_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  serial_q, serial_d;
  logic                  strobe_q, strobe_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [CNT_W-1:0]      cnt_value;
  logic [CNT_W-1:0]      cnt_load_value;
  logic                  cnt_tc;
  logic                  cnt_load;
  logic                  cnt_dec;

  logic                  ready;
  logic                  accept;

  // Word being advanced this cycle: the fresh input on accept, else the
  // remaining bits held in the shift register.
  logic [DATA_WIDTH-1:0] adv_word;
  logic [DATA_WIDTH-1:0] adv_rest;
  logic                  adv_bit;

  assign accept   = Data_Valid_In & ready;
  assign adv_word = accept ? Parallel_Data_In : shift_q;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign adv_bit  = adv_word[DATA_WIDTH-1];
      assign adv_rest = {adv_word[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign adv_bit  = adv_word[0];
      assign adv_rest = {1'b0, adv_word[DATA_WIDTH-1:1]};
    end
  endgenerate

  piso_bit_counter #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk_i       (Clk_In),
    .reset_i     (Reset_In),
    .load_i      (cnt_load),
    .dec_i       (cnt_dec),
    .load_value_i(cnt_load_value),
    .count_o     (cnt_value),
    .tc_o        (cnt_tc)
  );

  // Ready: idle, or the last bit of a word when streaming without gaps.
  always_comb begin
    ready = 1'b0;
    if (Enable_In && !Reset_In) begin
      case (state_q)
        ST_IDLE:  ready = 1'b1;
        ST_SHIFT: ready = cnt_tc && (GAP_CYCLES == 0);
        default:  ready = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; everything holds while disabled.
  always_comb begin
    state_d = state_q;
    if (Enable_In) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt_tc) begin
            if (GAP_CYCLES > 0) state_d = ST_GAP;
            else if (!accept)   state_d = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (cnt_tc) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values: load or advance the shift register, drive the
  // counter, and zero the serial outputs whenever the block is disabled.
  always_comb begin
    shift_d        = shift_q;
    serial_d       = 1'b0;
    strobe_d       = 1'b0;
    done_d         = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = BIT_LOAD;
    busy_d         = (state_d != ST_IDLE);
    if (Enable_In) begin
      if (accept) begin
        shift_d  = adv_rest;
        serial_d = adv_bit;
        strobe_d = 1'b1;
        cnt_load = 1'b1;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (!cnt_tc) begin
              shift_d  = adv_rest;
              serial_d = adv_bit;
              strobe_d = 1'b1;
              cnt_dec  = 1'b1;
              done_d   = (cnt_value == CNT_W'(1));
            end else if (GAP_CYCLES > 0) begin
              cnt_load       = 1'b1;
              cnt_load_value = GAP_LOAD;
            end
          end
          ST_GAP: begin
            cnt_dec = !cnt_tc;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Shift register and registered outputs, cleared asynchronously.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      shift_q  <= '0;
      serial_q <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      serial_q <= serial_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign Data_Ready_Out        = ready;
  assign Serial_Data_Out       = serial_q;
  assign Shift_Data_Signal_Out = strobe_q;
  assign Word_Done_Out         = done_q;
  assign Busy_Out              = busy_q;

endmodule

// File: tb/tb_parallel_in_serial_out_piso_tx.sv
// Bench for the PISO transmitter: three instances (default, 2-cycle gap,
// LSB-first), each feeding a behavioural 8-bit SIPO, checked every cycle
// against a word/bit-index reference model.
module tb_parallel_in_serial_out_piso_tx;

  localparam int W  = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         en   [NI];
  logic         vld  [NI];
  logic [W-1:0] dat  [NI];
  logic         rdy  [NI];
  logic         ser  [NI];
  logic         stb  [NI];
  logic         wdone[NI];
  logic         busy [NI];

  parallel_in_serial_out_piso_tx u_dut (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en[0]), .Parallel_Data_In(dat[0]),
    .Data_Valid_In(vld[0]), .Data_Ready_Out(rdy[0]), .Serial_Data_Out(ser[0]),
    .Shift_Data_Signal_Out(stb[0]), .Word_Done_Out(wdone[0]), .Busy_Out(busy[0]));

  parallel_in_serial_out_piso_tx #(.GAP_CYCLES(2)) u_gap (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en[1]), .Parallel_Data_In(dat[1]),
    .Data_Valid_In(vld[1]), .Data_Ready_Out(rdy[1]), .Serial_Data_Out(ser[1]),
    .Shift_Data_Signal_Out(stb[1]), .Word_Done_Out(wdone[1]), .Busy_Out(busy[1]));

  parallel_in_serial_out_piso_tx #(.MSB_FIRST(1'b0)) u_lsb (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en[2]), .Parallel_Data_In(dat[2]),
    .Data_Valid_In(vld[2]), .Data_Ready_Out(rdy[2]), .Serial_Data_Out(ser[2]),
    .Shift_Data_Signal_Out(stb[2]), .Word_Done_Out(wdone[2]), .Busy_Out(busy[2]));

  function automatic int gap_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 2);
  endfunction

  // Behavioural SIPO downstream of each instance: shifts left on negedge strobe.
  logic [W-1:0] sipo   [NI];
  logic [W-1:0] rx_word[NI];
  logic [W-1:0] rx_prev[NI];
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        sipo[i]    <= '0;
        rx_word[i] <= '0;
        rx_prev[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (stb[i]) begin
          sipo[i] <= {sipo[i][W-2:0], ser[i]};
          if (wdone[i]) begin
            rx_prev[i] <= rx_word[i];
            rx_word[i] <= {sipo[i][W-2:0], ser[i]};
          end
        end
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Upstream sources: words wait here until the reference model accepts them.
  logic [W-1:0] src0[$];
  logic [W-1:0] src1[$];
  logic [W-1:0] src2[$];
  bit           gate[NI];

  function automatic int src_size(input int i);
    case (i)
      0:       return src0.size();
      1:       return src1.size();
      default: return src2.size();
    endcase
  endfunction

  function automatic logic [W-1:0] src_front(input int i);
    if (src_size(i) == 0) return '0;
    case (i)
      0:       return src0[0];
      1:       return src1[0];
      default: return src2[0];
    endcase
  endfunction

  task automatic src_push(input int i, input logic [W-1:0] w);
    case (i)
      0:       src0.push_back(w);
      1:       src1.push_back(w);
      default: src2.push_back(w);
    endcase
  endtask

  task automatic src_pop(input int i);
    case (i)
      0:       void'(src0.pop_front());
      1:       void'(src1.pop_front());
      default: void'(src2.pop_front());
    endcase
  endtask

  // Reference model: the word in flight, which bit index is on the wire,
  // remaining gap cycles, and whether the last edge was enabled.
  bit           m_act[NI];
  logic [W-1:0] m_word[NI];
  int           m_idx[NI];
  int           m_gap[NI];
  bit           m_en [NI];
  bit           m_acc[NI];

  function automatic bit m_ready(input int i);
    if (rst || !en[i]) return 1'b0;
    if (!m_act[i]) return (m_gap[i] == 0);
    return (m_idx[i] == W - 1) && (gap_of(i) == 0);
  endfunction

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = w[W-1-b];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_act[i] = 1'b0;
      m_gap[i] = 0;
      m_idx[i] = 0;
      m_en[i]  = 1'b0;
      m_word[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    if (rst) begin
      m_act[i] = 1'b0;
      m_gap[i] = 0;
      m_en[i]  = 1'b0;
      return;
    end
    m_en[i] = en[i];
    if (!en[i]) return;
    if (m_acc[i]) src_pop(i);
    if (m_act[i]) begin
      if (m_idx[i] < W - 1) begin
        m_idx[i]++;
      end else if (gap_of(i) > 0) begin
        m_act[i] = 1'b0;
        m_gap[i] = gap_of(i);
      end else if (m_acc[i]) begin
        m_word[i] = dat[i];
        m_idx[i]  = 0;
      end else begin
        m_act[i] = 1'b0;
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
    end else if (m_acc[i]) begin
      m_act[i]  = 1'b1;
      m_word[i] = dat[i];
      m_idx[i]  = 0;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NI; i++) begin
      vld[i] = gate[i] && (src_size(i) > 0);
      dat[i] = vld[i] ? src_front(i) : W'($urandom);
    end
  endtask

  // One clock: present inputs, advance the model on the edge, compare at negedge.
  task automatic tick();
    bit exp_stb;
    bit exp_bit;
    drive_inputs();
    for (int i = 0; i < NI; i++) m_acc[i] = vld[i] && m_ready(i);
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    drive_inputs();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      exp_stb = m_en[i] && m_act[i];
      exp_bit = msb_of(i) ? m_word[i][W-1-m_idx[i]] : m_word[i][m_idx[i]];
      chk($sformatf("u%0d_strobe", i), stb[i], exp_stb);
      chk($sformatf("u%0d_serial", i), ser[i], exp_stb & exp_bit);
      chk($sformatf("u%0d_done", i), wdone[i], exp_stb && (m_idx[i] == W - 1));
      chk($sformatf("u%0d_busy", i), busy[i], m_act[i] || (m_gap[i] > 0));
      chk($sformatf("u%0d_ready", i), rdy[i], m_ready(i));
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      if (m_en[i] && m_act[i] && (m_idx[i] == W - 1))
        chk($sformatf("u%0d_sipo_word", i), rx_word[i],
            msb_of(i) ? m_word[i] : bitrev(m_word[i]));
    end
  endtask

  // Run until instance i has bit index idx on the wire, with a cycle budget.
  task automatic wait_bit(input int i, input int idx, input string tag);
    int n = 0;
    while (!(m_act[i] && m_en[i] && (m_idx[i] == idx)) && (n < 40)) begin
      tick();
      n++;
    end
    chk(tag, (n < 40), 1);
  endtask

  // Assert reset between clock edges and confirm outputs clear without a clock.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d_rst_strobe", i), stb[i], 0);
      chk($sformatf("u%0d_rst_serial", i), ser[i], 0);
      chk($sformatf("u%0d_rst_done", i), wdone[i], 0);
      chk($sformatf("u%0d_rst_busy", i), busy[i], 0);
      chk($sformatf("u%0d_rst_ready", i), rdy[i], 0);
    end
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      en[i]   = 1'b1;
      gate[i] = 1'b1;
      vld[i]  = 1'b0;
      dat[i]  = '0;
    end
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single MSB-first word.
    src_push(0, 8'hA5);
    repeat (12) tick();
    chk("t1_sipo", rx_word[0], 8'hA5);

    // Back-to-back words with valid held.
    src_push(0, 8'h3C);
    src_push(0, 8'hFF);
    repeat (20) tick();
    chk("t2_first", rx_prev[0], 8'h3C);
    chk("t2_second", rx_word[0], 8'hFF);

    // Two words through the gapped instance.
    src_push(1, 8'h5A);
    src_push(1, 8'hC3);
    repeat (26) tick();
    chk("t3_first", rx_prev[1], 8'h5A);
    chk("t3_second", rx_word[1], 8'hC3);

    // Enable stall mid-word.
    src_push(0, 8'h81);
    wait_bit(0, 3, "t4_wait_bit");
    en[0] = 1'b0;
    repeat (3) tick();
    en[0] = 1'b1;
    repeat (12) tick();
    chk("t4_sipo", rx_word[0], 8'h81);

    // Reset mid-word, then a clean word.
    src_push(0, 8'hC6);
    wait_bit(0, 4, "t5_wait_bit");
    mid_reset();
    src_push(0, 8'h0F);
    repeat (12) tick();
    chk("t5_sipo", rx_word[0], 8'h0F);

    // LSB-first: 0x01 goes out as 1 then seven zeros.
    src_push(2, 8'h01);
    repeat (12) tick();
    chk("t6_sipo", rx_word[2], 8'h80);

    // Random traffic, random valid bubbles and enable drops.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NI; i++) begin
        if ((src_size(i) < 3) && ($urandom_range(0, 3) == 0)) src_push(i, W'($urandom));
        gate[i] = ($urandom_range(0, 4) != 0);
        en[i]   = ($urandom_range(0, 7) != 0);
      end
      if (c == 700) mid_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
